riscv_axi_ifetch_master: RTL and testbench
==========================================

// Module: riscv_axi_ifetch_master
// PURPOSE
//  Bridges the RV32I pipeline's instruction-fetch request/response port onto the AXI4-Lite read
//  channel that feeds interconnect master port M0.
//  One fetch outstanding at a time; response is held in an output register until the core takes it.
//  Pipeline redirects are absorbed by a flush input: in-flight AXI beats are drained and discarded,
//  never returned to the core.
// PARAMETERS
//  ADDR_WIDTH  32       fetch/AXI address width
//  DATA_WIDTH  32       instruction word width (AXI RDATA width)
//  ARPROT_VAL  3'b100   constant driven on m_axi_arprot (instruction, secure, unprivileged)
//  CNT_WIDTH   32       width of the completed-fetch counter
// PORTS
//  ACLK                 in   1           clock
//  ARESETN              in   1           async active-low reset
//  cpu_req_valid        in   1           core presents a fetch address
//  cpu_req_addr         in   ADDR_WIDTH  fetch PC
//  cpu_req_ready        out  1           bridge accepts request this cycle
//  cpu_flush            in   1           redirect: abandon current fetch
//  cpu_rsp_valid        out  1           instruction word available
//  cpu_rsp_data         out  DATA_WIDTH  instruction word
//  cpu_rsp_err          out  1           fetch faulted (RRESP!=OKAY or misaligned PC)
//  cpu_rsp_ready        in   1           core consumes response
//  m_axi_araddr         out  ADDR_WIDTH  AXI read address
//  m_axi_arprot         out  3           = ARPROT_VAL
//  m_axi_arvalid        out  1           AXI read address valid
//  m_axi_arready        in   1           AXI read address ready
//  m_axi_rdata          in   DATA_WIDTH  AXI read data
//  m_axi_rresp          in   2           AXI read response
//  m_axi_rvalid         in   1           AXI read data valid
//  m_axi_rready         out  1           AXI read data ready
//  fetch_count          out  CNT_WIDTH   count of responses delivered to core (wraps)
// BEHAVIOUR
//  Reset (ARESETN low, async):
//   - state=IDLE; arvalid=0, rready=0, rsp_valid=0, rsp_data=0, rsp_err=0, araddr=0, fetch_count=0
//   - cpu_req_ready = (state==IDLE) & ~cpu_flush, registered-state derived -> 1 after reset release
//  States:
//   - IDLE: req accepted on cpu_req_valid & cpu_req_ready.
//     - addr[1:0]!=0 -> RSP with err=1, data=0, no bus access.
//     - otherwise: araddr<=addr, arvalid<=1 -> AR (AR asserted the cycle after accept).
//   - AR: hold arvalid/araddr stable until arready (AXI rule: never withdraw).
//     - on handshake: arvalid<=0, rready<=1 -> R.
//     - flush seen in AR (or on handshake cycle) sets drop flag; AR still completes -> DRAIN.
//   - R: on rvalid: rready<=0, rsp_data<=rdata, rsp_err<=(rresp!=2'b00), rsp_valid<=1 -> RSP.
//     - flush in R (without rvalid) -> DRAIN.
//     - flush coincident with rvalid -> beat discarded -> IDLE.
//   - DRAIN: rready=1; on rvalid discard beat, rready<=0 -> IDLE.
//   - RSP: hold rsp_* stable until cpu_rsp_ready.
//     - then rsp_valid<=0, fetch_count++ -> IDLE.
//     - flush in RSP -> drop response, no count -> IDLE.
//  Latency: accept->arvalid 1 cycle; rvalid->cpu_rsp_valid 1 cycle; zero-wait slave gives 3-cycle
//   fetch. Next request accepted the cycle after rsp consumption.
//  Invariants:
//   - flush has priority over rsp_ready and req_valid in the same cycle (no accept while flushing).
//   - fetch_count wraps modulo 2^CNT_WIDTH.
//   - AXI beats never reach cpu_rsp_* after a flush.
//  rready and arvalid are never simultaneously 1.
// STRUCTURE
//  Shared package riscv_axi_pkg:
//   - fetch state encoding (IDLE/AR/R/DRAIN/RSP)
//   - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
//   - ARPROT_INSTR constant
//  Single flat module; no sub-module needed (output holding register is inline).
// TESTING
//  1. Zero-wait RAM, req addr 0x0000_0010 -> one AR at 0x10; rsp data = mem[4], err=0, 3 cycles;
//     fetch_count=1.
//  2. arready delayed 5 cycles -> araddr/arvalid stable all 5 cycles; single AR handshake; data correct.
//  3. Flush 1 cycle after AR handshake, rvalid 4 cycles later -> beat drained (rready=1),
//     cpu_rsp_valid never 1; next req 0x20 returns mem[8].
//  4. Slave returns RRESP=2'b10 -> cpu_rsp_err=1, data=rdata; count increments.
//  5. Req addr 0x0000_0006 -> no arvalid ever; cpu_rsp_err=1 next cycle.
//  6. cpu_rsp_ready held low 10 cycles -> rsp stable, req_ready=0, no new AR.
//     Async reset mid-R -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_axi_pkg.sv
// rtl/riscv_axi_pkg.sv - shared fetch-state encoding and AXI read-response constants
package riscv_axi_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_AR    = 3'd1,
    FETCH_R     = 3'd2,
    FETCH_DRAIN = 3'd3,
    FETCH_RSP   = 3'd4
  } fetch_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // instruction access, secure, unprivileged
  localparam logic [2:0] ARPROT_INSTR = 3'b100;

endpackage

// File: rtl/riscv_axi_ifetch_master.sv
// rtl/riscv_axi_ifetch_master.sv - single-outstanding instruction fetch onto an AXI4-Lite read channel
module riscv_axi_ifetch_master
  import riscv_axi_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] ARPROT_VAL = ARPROT_INSTR,
  parameter int         CNT_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cpu_req_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  output logic                  cpu_req_ready,
  input  logic                  cpu_flush,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_data,
  output logic                  cpu_rsp_err,
  input  logic                  cpu_rsp_ready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  fetch_state_e          state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  drop_q, drop_d;

  assign cpu_req_ready = (state_q == FETCH_IDLE) && !cpu_flush;
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_data  = rsp_data_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = ARPROT_VAL;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign fetch_count   = count_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= FETCH_IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      araddr_q    <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      araddr_q    <= araddr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    araddr_d    = araddr_q;
    count_d     = count_q;
    drop_d      = drop_q;

    unique case (state_q)
      FETCH_IDLE: begin
        if (cpu_req_valid && cpu_req_ready) begin
          if (cpu_req_addr[1:0] != 2'b00) begin
            // misaligned PC faults locally without touching the bus
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = FETCH_RSP;
          end else begin
            araddr_d  = cpu_req_addr;
            arvalid_d = 1'b1;
            state_d   = FETCH_AR;
          end
        end
      end

      FETCH_AR: begin
        // an issued AR can never be withdrawn, so a flush here only marks the beat for discard
        drop_d = drop_q || cpu_flush;
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          drop_d    = 1'b0;
          state_d   = (drop_q || cpu_flush) ? FETCH_DRAIN : FETCH_R;
        end
      end

      FETCH_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (cpu_flush) begin
            state_d = FETCH_IDLE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = m_axi_rdata;
            rsp_err_d   = (m_axi_rresp != AXI_RESP_OKAY);
            state_d     = FETCH_RSP;
          end
        end else if (cpu_flush) begin
          state_d = FETCH_DRAIN;
        end
      end

      FETCH_DRAIN: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = FETCH_IDLE;
        end
      end

      FETCH_RSP: begin
        if (cpu_flush) begin
          rsp_valid_d = 1'b0;
          state_d     = FETCH_IDLE;
        end else if (cpu_rsp_ready) begin
          rsp_valid_d = 1'b0;
          count_d     = count_q + CNT_WIDTH'(1);
          state_d     = FETCH_IDLE;
        end
      end

      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_axi_ifetch_master.sv
// tb/tb_riscv_axi_ifetch_master.sv - directed plus randomized check of the fetch bridge against a transaction model
module tb_riscv_axi_ifetch_master;
  import riscv_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cpu_req_valid, cpu_req_ready, cpu_flush;
  logic [31:0] cpu_req_addr;
  logic        cpu_rsp_valid, cpu_rsp_err, cpu_rsp_ready;
  logic [31:0] cpu_rsp_data;
  logic [31:0] m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_rresp;
  logic [31:0] fetch_count;

  always #5 ACLK = ~ACLK;

  riscv_axi_ifetch_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
    .cpu_flush(cpu_flush),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_err(cpu_rsp_err),
    .cpu_rsp_ready(cpu_rsp_ready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .fetch_count(fetch_count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [0:63];

  // transaction model: what the core and the bus should observe
  logic        m_arvalid, m_rready, m_rsp_valid, m_rsp_err, m_discard;
  logic [31:0] m_araddr, m_rsp_data, m_count;

  // slave: one pending read beat with programmable latencies
  logic        s_pend;
  logic [31:0] s_addr;
  logic [1:0]  s_resp;
  int ar_cnt, r_cnt, ar_lat, r_lat;
  int ar_lo = 0, ar_hi = 0, r_lo = 0, r_hi = 0, resp_force = -1;
  int stall_cnt, hs_cnt, rhs_cnt, rsp_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick_resp();
    int r;
    if (resp_force >= 0) return resp_force[1:0];
    r = int'($urandom_range(7, 0));
    if (r == 5) return AXI_RESP_SLVERR;
    if (r == 6) return AXI_RESP_DECERR;
    if (r == 7) return AXI_RESP_EXOKAY;
    return AXI_RESP_OKAY;
  endfunction

  task automatic model_reset();
    m_arvalid = 0; m_rready = 0; m_rsp_valid = 0; m_rsp_err = 0; m_discard = 0;
    m_araddr = 0; m_rsp_data = 0; m_count = 0;
    s_pend = 0; s_addr = 0; s_resp = 0; ar_cnt = 0; r_cnt = 0; ar_lat = 0; r_lat = 0;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic f, input logic rr);
    cpu_req_valid = v; cpu_req_addr = a; cpu_flush = f; cpu_rsp_ready = rr;
  endtask

  // one clock: drive slave, check combinational ready, advance model, check registered outputs
  task automatic step();
    logic pa, pr, f, idle;
    logic [31:0] pad;
    m_axi_arready = m_arvalid && (ar_cnt >= ar_lat);
    m_axi_rvalid  = s_pend && (r_cnt >= r_lat);
    m_axi_rdata   = s_pend ? mem[s_addr[7:2]] : $urandom;
    m_axi_rresp   = s_pend ? s_resp : 2'($urandom_range(3, 0));
    #1;
    idle = !m_arvalid && !m_rready && !m_rsp_valid;
    chk("req_ready", 32'(cpu_req_ready), 32'(idle && !cpu_flush));
    chk("ar_r_excl", 32'(m_axi_arvalid && m_axi_rready), 32'(0));
    if (m_axi_arvalid && !m_axi_arready) stall_cnt++;
    if (m_axi_arvalid && m_axi_arready) hs_cnt++;
    if (m_axi_rvalid && m_axi_rready) rhs_cnt++;
    if (cpu_rsp_valid) rsp_seen++;

    pa = m_arvalid; pr = m_rready; pad = m_araddr; f = cpu_flush;
    if (m_rsp_valid) begin
      if (f) m_rsp_valid = 0;
      else if (cpu_rsp_ready) begin m_rsp_valid = 0; m_count = m_count + 1; end
    end else if (m_arvalid) begin
      if (f) m_discard = 1;
      if (m_axi_arready) begin m_arvalid = 0; m_rready = 1; end
    end else if (m_rready) begin
      if (m_axi_rvalid) begin
        m_rready = 0;
        if (!(m_discard || f)) begin
          m_rsp_valid = 1; m_rsp_data = m_axi_rdata; m_rsp_err = (m_axi_rresp != AXI_RESP_OKAY);
        end
        m_discard = 0;
      end else if (f) m_discard = 1;
    end else if (cpu_req_valid && !f) begin
      if (cpu_req_addr[1:0] != 2'b00) begin
        m_rsp_valid = 1; m_rsp_err = 1; m_rsp_data = 0;
      end else begin
        m_arvalid = 1; m_araddr = cpu_req_addr;
        ar_cnt = 0; ar_lat = int'($urandom_range(ar_hi, ar_lo));
      end
    end

    if (s_pend) begin
      if (m_axi_rvalid && pr) s_pend = 0;
      else r_cnt++;
    end
    if (pa) begin
      if (m_axi_arready) begin
        s_pend = 1; s_addr = pad; s_resp = pick_resp();
        r_cnt = 0; r_lat = int'($urandom_range(r_hi, r_lo));
      end else ar_cnt++;
    end

    @(posedge ACLK); #1;
    chk("arvalid", 32'(m_axi_arvalid), 32'(m_arvalid));
    chk("araddr", m_axi_araddr, m_araddr);
    chk("rready", 32'(m_axi_rready), 32'(m_rready));
    chk("rsp_valid", 32'(cpu_rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      chk("rsp_data", cpu_rsp_data, m_rsp_data);
      chk("rsp_err", 32'(cpu_rsp_err), 32'(m_rsp_err));
    end
    chk("fetch_count", fetch_count, m_count);
    @(negedge ACLK);
  endtask

  task automatic clear_counters();
    stall_cnt = 0; hs_cnt = 0; rhs_cnt = 0; rsp_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(m_axi_arvalid), 32'(0));
    chk({tag, "_rready"}, 32'(m_axi_rready), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(cpu_rsp_valid), 32'(0));
    chk({tag, "_rsp_err"}, 32'(cpu_rsp_err), 32'(0));
    chk({tag, "_rsp_data"}, cpu_rsp_data, 32'h0);
    chk({tag, "_araddr"}, m_axi_araddr, 32'h0);
    chk({tag, "_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4]  = 32'h0040_0093;
    mem[5]  = 32'h5555_0005;
    mem[6]  = 32'h6666_0006;
    mem[8]  = 32'h8888_0008;
    mem[17] = 32'h1717_0017;
    ARESETN = 1'b0;
    set_in(0, 0, 0, 0);
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    model_reset();
    clear_counters();
    repeat (2) @(negedge ACLK);
    check_reset_outputs("reset");
    chk("arprot", 32'(m_axi_arprot), 32'(3'b100));
    ARESETN = 1'b1;
    #1;
    chk("reset_req_ready", 32'(cpu_req_ready), 32'(1));
    @(negedge ACLK);

    // zero-wait fetch of 0x10: three clocks to response
    set_in(1, 32'h10, 0, 0); step();
    chk("t1_araddr", m_axi_araddr, 32'h10);
    set_in(0, 0, 0, 0); step(); step();
    chk("t1_rsp_valid", 32'(cpu_rsp_valid), 32'(1));
    chk("t1_rsp_data", cpu_rsp_data, 32'h0040_0093);
    set_in(0, 0, 0, 1); step();
    chk("t1_count", fetch_count, 32'd1);

    // arready held off five cycles
    ar_lo = 5; ar_hi = 5; clear_counters();
    set_in(1, 32'h44, 0, 0); step();
    set_in(0, 0, 0, 0);
    repeat (8) step();
    chk("t2_stalls", 32'(stall_cnt), 32'd5);
    chk("t2_ar_hs", 32'(hs_cnt), 32'd1);
    chk("t2_rsp_data", cpu_rsp_data, 32'h1717_0017);
    set_in(0, 0, 0, 1); step();
    ar_lo = 0; ar_hi = 0;

    // flush after AR handshake; late beat drained, never delivered
    r_lo = 4; r_hi = 4;
    set_in(1, 32'h30, 0, 0); step();
    set_in(0, 0, 0, 0); step();
    clear_counters();
    set_in(0, 0, 1, 0); step();
    set_in(0, 0, 0, 0); repeat (6) step();
    chk("t3_rsp_seen", 32'(rsp_seen), 32'd0);
    chk("t3_drained", 32'(rhs_cnt), 32'd1);
    r_lo = 0; r_hi = 0;
    set_in(1, 32'h20, 0, 0); step();
    set_in(0, 0, 0, 0); step(); step();
    chk("t3_rsp_data", cpu_rsp_data, 32'h8888_0008);
    set_in(0, 0, 0, 1); step();
    chk("t3_count", fetch_count, 32'd3);

    // slave error response
    resp_force = 2;
    set_in(1, 32'h14, 0, 0); step();
    set_in(0, 0, 0, 0); step(); step();
    chk("t4_rsp_err", 32'(cpu_rsp_err), 32'(1));
    chk("t4_rsp_data", cpu_rsp_data, 32'h5555_0005);
    set_in(0, 0, 0, 1); step();
    chk("t4_count", fetch_count, 32'd4);
    resp_force = -1;

    // misaligned PC: immediate fault, no bus traffic
    clear_counters();
    set_in(1, 32'h6, 0, 0); step();
    chk("t5_rsp_valid", 32'(cpu_rsp_valid), 32'(1));
    chk("t5_rsp_err", 32'(cpu_rsp_err), 32'(1));
    set_in(0, 0, 0, 1); step();
    chk("t5_no_ar", 32'(stall_cnt + hs_cnt), 32'd0);
    chk("t5_count", fetch_count, 32'd5);

    // core stalls the response for ten cycles
    set_in(1, 32'h18, 0, 0); step();
    set_in(0, 0, 0, 0); step(); step();
    clear_counters();
    set_in(1, 32'h1c, 0, 0); repeat (10) step();
    chk("t6_no_ar", 32'(stall_cnt + hs_cnt), 32'd0);
    chk("t6_rsp_data", cpu_rsp_data, 32'h6666_0006);
    set_in(0, 0, 0, 1); step();
    chk("t6_count", fetch_count, 32'd6);

    // asynchronous reset while waiting for the read beat
    r_lo = 8; r_hi = 8;
    set_in(1, 32'h40, 0, 0); step();
    set_in(0, 0, 0, 0); step();
    chk("t7_in_r", 32'(m_axi_rready), 32'(1));
    #2 ARESETN = 1'b0;
    #1 check_reset_outputs("t7");
    model_reset();
    m_axi_rvalid = 0; m_axi_arready = 0;
    @(negedge ACLK); @(negedge ACLK);
    ARESETN = 1'b1;
    r_lo = 0; r_hi = 3; ar_lo = 0; ar_hi = 3;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] w;
      logic [1:0] lo;
      w  = 6'($urandom_range(63, 0));
      lo = ($urandom_range(15, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      set_in($urandom_range(9, 0) < 7, {24'h0, w, lo}, $urandom_range(11, 0) == 0,
             1'($urandom_range(1, 0)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
